// File: rtl/exe2_pkg.sv
// exe2_pkg: shared constants for the exe unit 2 APB register front-end.
// Holds the register index map, STATUS/CTRL bit positions and the launch FSM state enum.
package exe2_pkg;

    // Register indices (word addresses)
    localparam int unsigned IDX_ARG_A  = 0;
    localparam int unsigned IDX_ARG_B  = 1;
    localparam int unsigned IDX_CTRL   = 2;
    localparam int unsigned IDX_RESULT = 3;
    localparam int unsigned IDX_STATUS = 4;

    // STATUS bit positions
    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;
    localparam int unsigned STATUS_ERROR_BIT = 2;

    // CTRL start bit position (op occupies the low bits)
    localparam int unsigned CTRL_START_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_CAPTURE = 2'd2
    } exe2_state_e;

endpackage : exe2_pkg

// File: rtl/exe2_apb_decode.sv
// exe2_apb_decode: APB access-phase qualification, address decode, wait-state
// and slave-error generation for the exe unit 2 register block. Purely combinational.
// Ports:
//   i_psel/i_penable/i_pwrite/i_paddr : APB request
//   i_busy      : launch FSM not idle
//   i_error     : captured STATUS.error
//   o_pready_c  : transfer completion (low only for RESULT read while busy)
//   o_pslverr_c : transfer error (only with EXE2_PSLVERR_EN, else 0)
//   o_wr_*_c    : register write strobes, already gated by completion and busy
//   o_rd_en_c   : read completing this cycle
//   o_rd_status_c : STATUS read completing this cycle (clears done)
// Macro: EXE2_PSLVERR_EN enables o_pslverr_c reporting.
module exe2_apb_decode
    import exe2_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic              i_busy,
    input  logic              i_error,
    output logic              o_pready_c,
    output logic              o_pslverr_c,
    output logic              o_wr_arg_a_c,
    output logic              o_wr_arg_b_c,
    output logic              o_wr_ctrl_c,
    output logic              o_rd_en_c,
    output logic              o_rd_status_c
);

    logic access_c;
    logic complete_c;
    logic wr_c;
    logic rd_c;
    logic hit_a_c;
    logic hit_b_c;
    logic hit_ctrl_c;
    logic hit_result_c;
    logic hit_status_c;
    logic mapped_c;

    // Address decode and transfer qualification
    always_comb begin
        hit_a_c      = (i_paddr == ADDR_W'(IDX_ARG_A));
        hit_b_c      = (i_paddr == ADDR_W'(IDX_ARG_B));
        hit_ctrl_c   = (i_paddr == ADDR_W'(IDX_CTRL));
        hit_result_c = (i_paddr == ADDR_W'(IDX_RESULT));
        hit_status_c = (i_paddr == ADDR_W'(IDX_STATUS));
        mapped_c     = hit_a_c | hit_b_c | hit_ctrl_c | hit_result_c | hit_status_c;

        access_c   = i_psel & i_penable;
        // Result is not yet stable while an operation is in flight: stall the read
        o_pready_c = ~(access_c & ~i_pwrite & hit_result_c & i_busy);
        complete_c = access_c & o_pready_c;
        wr_c       = complete_c & i_pwrite;
        rd_c       = complete_c & ~i_pwrite;

        // Operand/control writes are dropped while busy to keep exe unit inputs stable
        o_wr_arg_a_c  = wr_c & hit_a_c & ~i_busy;
        o_wr_arg_b_c  = wr_c & hit_b_c & ~i_busy;
        o_wr_ctrl_c   = wr_c & hit_ctrl_c & ~i_busy;
        o_rd_en_c     = rd_c;
        o_rd_status_c = rd_c & hit_status_c;
    end

`ifdef EXE2_PSLVERR_EN
    // Error flagged in the completing cycle only
    always_comb begin
        o_pslverr_c = complete_c & (
                          (wr_c & (hit_result_c | hit_status_c))
                        | ~mapped_c
                        | (wr_c & i_busy & (hit_a_c | hit_b_c | hit_ctrl_c))
                        | (rd_c & hit_result_c & i_error));
    end
`else
    logic unused_error;
    assign unused_error = i_error;
    assign o_pslverr_c  = 1'b0;
`endif

endmodule : exe2_apb_decode

// File: rtl/exe2_apb_regs.sv
// exe2_apb_regs: APB register front-end for exe unit 2. Holds operands, opcode and
// a start/launch FSM; captures exe unit result and error into RESULT/STATUS.
// Ports:
//   i_clk, i_rst (async, active-high)
//   APB: i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, o_prdata, o_pready, o_pslverr
//   exe unit: o_argA, o_argB, o_op (registered), i_result, i_error
//   o_done : set on capture, cleared by STATUS read (set wins on collision)
// Macro: EXE2_PSLVERR_EN enables APB slave-error reporting (default: o_pslverr = 0).
module exe2_apb_regs
    import exe2_pkg::*;
#(
    parameter int unsigned BITS   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned OP_W   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic [DATA_W-1:0] o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [BITS-1:0]   o_argA,
    output logic [BITS-1:0]   o_argB,
    output logic [OP_W-1:0]   o_op,
    input  logic [BITS-1:0]   i_result,
    input  logic              i_error,
    output logic              o_done
);

    exe2_state_e     state_q, state_d;
    logic [BITS-1:0] arg_a_q, arg_a_d;
    logic [BITS-1:0] arg_b_q, arg_b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [BITS-1:0] result_q, result_d;
    logic            error_q, error_d;
    logic            done_q, done_d;

    logic busy_c;
    logic wr_arg_a_c;
    logic wr_arg_b_c;
    logic wr_ctrl_c;
    logic rd_en_c;
    logic rd_status_c;
    logic [DATA_W-1:0] status_c;

    // Only the operand, op and start fields of the write data are consumed
    logic unused_pwdata;
    assign unused_pwdata = ^i_pwdata;

    assign busy_c = (state_q != ST_IDLE);

    exe2_apb_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .i_psel        (i_psel),
        .i_penable     (i_penable),
        .i_pwrite      (i_pwrite),
        .i_paddr       (i_paddr),
        .i_busy        (busy_c),
        .i_error       (error_q),
        .o_pready_c    (o_pready),
        .o_pslverr_c   (o_pslverr),
        .o_wr_arg_a_c  (wr_arg_a_c),
        .o_wr_arg_b_c  (wr_arg_b_c),
        .o_wr_ctrl_c   (wr_ctrl_c),
        .o_rd_en_c     (rd_en_c),
        .o_rd_status_c (rd_status_c)
    );

    // Next-state: register writes, launch FSM, result capture
    always_comb begin
        state_d  = state_q;
        arg_a_d  = arg_a_q;
        arg_b_d  = arg_b_q;
        op_d     = op_q;
        result_d = result_q;
        error_d  = error_q;
        done_d   = done_q;

        if (wr_arg_a_c) arg_a_d = i_pwdata[BITS-1:0];
        if (wr_arg_b_c) arg_b_d = i_pwdata[BITS-1:0];
        if (wr_ctrl_c)  op_d    = i_pwdata[OP_W-1:0];
        if (rd_status_c) done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // wr_ctrl_c is already suppressed while busy, so a start here is always legal
                if (wr_ctrl_c && i_pwdata[CTRL_START_BIT]) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d  = ST_IDLE;
                result_d = i_result;
                error_d  = i_error;
                done_d   = 1'b1;   // overrides a coincident STATUS-read clear
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register flops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            arg_a_q  <= '0;
            arg_b_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            arg_a_q  <= arg_a_d;
            arg_b_q  <= arg_b_d;
            op_q     <= op_d;
            result_q <= result_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    // Read mux: data only on a completing read, zero otherwise
    always_comb begin
        status_c                   = '0;
        status_c[STATUS_BUSY_BIT]  = busy_c;
        status_c[STATUS_DONE_BIT]  = done_q;
        status_c[STATUS_ERROR_BIT] = error_q;

        o_prdata = '0;
        if (rd_en_c) begin
            if (i_paddr == ADDR_W'(IDX_ARG_A))       o_prdata = DATA_W'(arg_a_q);
            else if (i_paddr == ADDR_W'(IDX_ARG_B))  o_prdata = DATA_W'(arg_b_q);
            else if (i_paddr == ADDR_W'(IDX_CTRL))   o_prdata = DATA_W'(op_q);
            else if (i_paddr == ADDR_W'(IDX_RESULT)) o_prdata = DATA_W'(result_q);
            else if (i_paddr == ADDR_W'(IDX_STATUS)) o_prdata = status_c;
        end
    end

    assign o_argA = arg_a_q;
    assign o_argB = arg_b_q;
    assign o_op   = op_q;
    assign o_done = done_q;

endmodule : exe2_apb_regs

// File: tb/tb_exe2_apb_regs.sv
// tb_exe2_apb_regs: directed bench for exe2_apb_regs with a small exe unit 2 model
// (op0 toggle bit, op1 set bit, op2 clear bit, op3 pass A; error when B >= 4).
module tb_exe2_apb_regs;

`ifdef EXE2_PSLVERR_EN
    localparam bit PSLV = 1'b1;
`else
    localparam bit PSLV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready, pslverr;
    logic [3:0] arg_a, arg_b;
    logic [1:0] op;
    logic [3:0] result;
    logic       error;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe2_apb_regs dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .o_prdata  (prdata),
        .o_pready  (pready),
        .o_pslverr (pslverr),
        .o_argA    (arg_a),
        .o_argB    (arg_b),
        .o_op      (op),
        .i_result  (result),
        .i_error   (error),
        .o_done    (done)
    );

    // Exe unit 2 behavioural model
    always_comb begin
        logic [3:0] mask;
        mask   = 4'b0001 << arg_b[1:0];
        error  = (arg_b >= 4'd4);
        result = arg_a;
        if (!error) begin
            case (op)
                2'd0:    result = arg_a ^ mask;
                2'd1:    result = arg_a | mask;
                2'd2:    result = arg_a & ~mask;
                default: result = arg_a;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer; starts and ends 1 time unit after a rising edge
    task automatic apb(input bit wr, input logic [3:0] addr, input logic [7:0] wdata,
                       input bit skip_setup,
                       output logic [7:0] rdata, output logic err, output int waits);
        psel   = 1'b1;
        pwrite = wr;
        paddr  = addr;
        pwdata = wdata;
        waits  = 0;
        if (!skip_setup) begin
            penable = 1'b0;
            @(posedge clk); #1;
        end
        penable = 1'b1;
        #1;
        while (!pready && waits < 20) begin
            @(posedge clk); #2;
            waits++;
        end
        if (waits >= 20) begin
            checks++;
            errors++;
            $display("FAIL apb_timeout: pready still 0 after %0d cycles, expected 1", waits);
        end
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [7:0] wdata);
        logic [7:0] rd; logic e; int w;
        apb(1'b1, addr, wdata, 1'b0, rd, e, w);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] addr,
                          input logic [7:0] exp, input bit exp_err);
        logic [7:0] rd; logic e; int w;
        apb(1'b0, addr, 8'h00, 1'b0, rd, e, w);
        check({name, "_rdata"}, 32'(rd), 32'(exp));
        check({name, "_slverr"}, 32'(e), 32'(exp_err));
    endtask

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [7:0] rd;
        logic e;
        int w;

        vecs[0]  = '{1'b1, 4'd0, 8'h01, 8'h00, 1'b0};   // ARG_A = 1
        vecs[1]  = '{1'b1, 4'd1, 8'h02, 8'h00, 1'b0};   // ARG_B = 2
        vecs[2]  = '{1'b0, 4'd0, 8'h00, 8'h01, 1'b0};
        vecs[3]  = '{1'b0, 4'd1, 8'h00, 8'h02, 1'b0};
        vecs[4]  = '{1'b1, 4'd2, 8'h03, 8'h00, 1'b0};   // op 3, no start
        vecs[5]  = '{1'b0, 4'd2, 8'h00, 8'h03, 1'b0};
        vecs[6]  = '{1'b0, 4'd4, 8'h00, 8'h00, 1'b0};   // STATUS idle
        vecs[7]  = '{1'b1, 4'd3, 8'h55, 8'h00, PSLV};   // write to RO RESULT
        vecs[8]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 4'd7, 8'h00, 8'h00, PSLV};   // unmapped read
        vecs[10] = '{1'b1, 4'd9, 8'hAA, 8'h00, PSLV};   // unmapped write
        vecs[11] = '{1'b1, 4'd0, 8'h1F, 8'h00, 1'b0};   // truncated to BITS
        vecs[12] = '{1'b0, 4'd0, 8'h00, 8'h0F, 1'b0};
        vecs[13] = '{1'b1, 4'd2, 8'h00, 8'h00, 1'b0};   // op 0, no start

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check("rst_pready", 32'(pready), 32'd1);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", 32'(prdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_argA", 32'(arg_a), 32'd0);
        check("rst_argB", 32'(arg_b), 32'd0);
        check("rst_op", 32'(op), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven zero-wait accesses
        for (int i = 0; i < 14; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, e, w);
            check($sformatf("vec%0d_slverr", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_waits", i), 32'(w), 32'd0);
            if (!vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
        end
        check("tbl_argA", 32'(arg_a), 32'h0F);
        check("tbl_argB", 32'(arg_b), 32'h02);
        check("tbl_op", 32'(op), 32'h0);

        // Basic operation: 1 ^ (1<<2) = 5
        wr_reg(4'd0, 8'h01);
        wr_reg(4'd1, 8'h02);
        wr_reg(4'd2, 8'h80);
        check("launch_done_early", 32'(done), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("basic_done", 32'(done), 32'd1);
        rd_chk("basic_result", 4'd3, 8'h05, 1'b0);
        rd_chk("basic_status", 4'd4, 8'h02, 1'b0);
        check("basic_done_cleared", 32'(done), 32'd0);
        rd_chk("basic_ctrl_start_reads0", 4'd2, 8'h00, 1'b0);

        // STATUS read completing on the capture edge: done must survive
        wr_reg(4'd2, 8'h80);
        rd_chk("coinc_status", 4'd4, 8'h01, 1'b0);
        check("coinc_done", 32'(done), 32'd1);
        rd_chk("coinc_status2", 4'd4, 8'h02, 1'b0);

        // RESULT read while busy: two wait states, then 3 ^ 4 = 7
        wr_reg(4'd0, 8'h03);
        wr_reg(4'd2, 8'h80);
        apb(1'b0, 4'd3, 8'h00, 1'b1, rd, e, w);
        check("wait_cycles", 32'(w), 32'd2);
        check("wait_rdata", 32'(rd), 32'h07);
        check("wait_slverr", 32'(e), 32'd0);

        // ARG_A write while busy is dropped
        wr_reg(4'd0, 8'h01);
        wr_reg(4'd2, 8'h80);
        apb(1'b1, 4'd0, 8'h0F, 1'b0, rd, e, w);
        check("busy_wr_slverr", 32'(e), 32'(PSLV));
        check("busy_wr_waits", 32'(w), 32'd0);
        @(posedge clk); #1;
        check("busy_wr_argA", 32'(arg_a), 32'h01);
        rd_chk("busy_wr_readA", 4'd0, 8'h01, 1'b0);

        // Error capture: B = 4 is out of range
        wr_reg(4'd1, 8'h04);
        wr_reg(4'd2, 8'h80);
        @(posedge clk); @(posedge clk); #1;
        rd_chk("err_status", 4'd4, 8'h06, 1'b0);
        rd_chk("err_result", 4'd3, 8'h01, PSLV);

        // Reset during CAPTURE
        wr_reg(4'd0, 8'h05);
        wr_reg(4'd2, 8'h80);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_argA", 32'(arg_a), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pready", 32'(pready), 32'd1);
        check("midrst_prdata", 32'(prdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("midrst_status", 4'd4, 8'h00, 1'b0);
        rd_chk("midrst_result", 4'd3, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_exe2_apb_regs

// File: doc/exe2_apb_regs.md
# exe2_apb_regs

APB slave register front-end for execution unit 2. Holds operand, opcode and control registers written over APB, drives them into the combinational exe unit 2 datapath (changebit and sibling operations), and captures `o_result`/`error` into read-only result and status registers. Sits directly upstream of `exe_unit_2`, between the APB bus and the ALU operation.

## Interface
Parameters:
- `BITS`, 4: operand/result width fed to exe unit 2.
- `DATA_W`, 8: APB data width; `BITS <= DATA_W`.
- `ADDR_W`, 4: APB address width (word index, no byte lanes).
- `OP_W`, 2: opcode width forwarded to exe unit 2.

Ports:
- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_psel`, `i_penable`, `i_pwrite`  in  1  APB control.
- `i_paddr`  in  ADDR_W  register index.
- `i_pwdata`  in  DATA_W  write data.
- `o_prdata`  out  DATA_W  read data, valid when `o_pready`=1 in access phase, else 0.
- `o_pready`  out  1  transfer completion.
- `o_pslverr`  out  1  transfer error (see Configuration).
- `o_argA`, `o_argB`  out  BITS  operands to exe unit 2.
- `o_op`  out  OP_W  operation select.
- `i_result`  in  BITS  exe unit 2 result.
- `i_error`  in  1  exe unit 2 error flag.
- `o_done`  out  1  level, set on capture, cleared by STATUS read.

## Operation
- Register map (index): 0 ARG_A (RW, low BITS), 1 ARG_B (RW, low BITS), 2 CTRL (W: [OP_W-1:0] op, bit 7 start; reads op, start reads 0), 3 RESULT (RO, low BITS), 4 STATUS (RO: bit0 busy, bit1 done, bit2 error). Unused read bits 0; other indices read 0.
- Writes take effect on the edge completing the access phase (`psel & penable & pready`).
- FSM: IDLE -> LAUNCH on CTRL write with start=1; LAUNCH -> CAPTURE unconditionally; CAPTURE -> IDLE, latching `i_result` into RESULT, `i_error` into STATUS.error, setting done.
- busy = state != IDLE. ARG_A/ARG_B/CTRL writes while busy are ignored (operands held stable for exe unit).
- Start while busy: ignored.
- STATUS read completion clears done; if capture and clear coincide, set wins.
- `o_argA/o_argB/o_op` are direct register outputs.

## Timing
- Reset: all registers 0, FSM IDLE, `o_prdata`=0, `o_pready`=1, `o_pslverr`=0, `o_done`=0, outputs to exe unit 0.
- Start write completes at edge N: busy=1 after N, LAUNCH N..N+1, CAPTURE N+1..N+2, result/done visible after edge N+2, busy=0.
- Access with RESULT read while busy: `o_pready`=0 (wait states) until FSM returns to IDLE; data then returned with pready=1 the following access cycle. All other accesses zero-wait.
- Reset mid-operation: FSM to IDLE immediately, pending access abandoned, RESULT/STATUS cleared.

## Configuration
- `EXE2_PSLVERR_EN` defined: `o_pslverr`=1 with `o_pready` on write to RO index (3,4), access to unmapped index, write/start while busy, or RESULT read when STATUS.error=1. Register contents unaffected by erroring writes.
- Undefined: `o_pslverr` tied 0; same cases silently ignored.

## Structure
- `exe2_pkg`: register index constants, STATUS bit positions, CTRL start bit position, FSM state enum (IDLE, LAUNCH, CAPTURE).
- One sub-module natural: `exe2_apb_decode` (access-phase qualification, address decode, wait-state and pslverr generation); FSM and registers in top.

## Test plan
- Reset mid-CAPTURE -> STATUS=0, RESULT=0, pready=1, argA=0 next cycle.
- Write A=4'b0001, B=2, CTRL=0x80 (op 0); model returns 4'b0101 -> after 3 cycles RESULT=0x05, STATUS=0x02, o_done=1; STATUS read clears done.
- Read RESULT on cycle after start -> pready low 2 cycles, then prdata=captured result.
- Write ARG_A=0xF while busy -> ARG_A unchanged; with `EXE2_PSLVERR_EN` pslverr=1, else 0.
- Model `i_error`=1 for B=4 on BITS=4 -> STATUS=0x06; RESULT read gives pslverr=1 only with macro.
- STATUS read completing same edge as capture -> done remains 1.
